// File: rtl/peri_uart_tx_pkg.sv
// Shared types and register addresses for the peri_uart_tx Wishbone UART transmitter.
package peri_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  localparam logic [3:0] AdrData   = 4'h0;
  localparam logic [3:0] AdrStatus = 4'h1;
  localparam logic [3:0] AdrDivLo  = 4'h2;
  localparam logic [3:0] AdrDivHi  = 4'h3;
  localparam logic [3:0] AdrLevel  = 4'h4;

  function automatic logic [7:0] status_byte(input logic ovf, input logic busy,
                                             input logic full, input logic empty);
    return {4'b0000, ovf, busy, full, empty};
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module fifo_sync #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CountFull);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/peri_uart_tx.sv
// Wishbone B4 classic responder feeding an 8N1 serial transmitter through a byte FIFO.
module peri_uart_tx
  import peri_uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          ack_q;
  logic [7:0]    rdat_q, rdat_d;
  logic [15:0]   div_q;
  logic          ovf_q;

  state_e        state_q;
  logic [15:0]   cnt_q;
  logic [7:0]    sh_q;
  logic [2:0]    idx_q;
  logic          tx_q;

  logic          access, wr, rd, push;
  logic          fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          cnt_zero;

  assign access = wb_stb_i & ~ack_q;
  assign wr     = access & wb_we_i;
  assign rd     = access & ~wb_we_i;
  assign push   = wr & (wb_adr_i == AdrData);

  assign cnt_zero = (cnt_q == '0);
  // A frame is loaded from idle, or straight out of a finishing stop bit so frames abut.
  assign fifo_pop = ~fifo_empty &
                    ((state_q == StIdle) | ((state_q == StStop) & cnt_zero));

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (wb_dat_i),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign busy_o   = (state_q != StIdle) | ~fifo_empty;
  assign tx_o     = tx_q;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;

  always_comb begin
    rdat_d = '0;
    if (rd) begin
      case (wb_adr_i)
        AdrStatus: rdat_d = status_byte(ovf_q, busy_o, fifo_full, fifo_empty);
        AdrDivLo:  rdat_d = div_q[7:0];
        AdrDivHi:  rdat_d = div_q[15:8];
        AdrLevel:  rdat_d = 8'(fifo_count);
        default:   rdat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      div_q  <= DIV_RESET;
      ovf_q  <= 1'b0;
    end else begin
      ack_q  <= access;
      rdat_q <= rdat_d;
      if (wr && wb_adr_i == AdrDivLo) div_q[7:0]  <= wb_dat_i;
      if (wr && wb_adr_i == AdrDivHi) div_q[15:8] <= wb_dat_i;
      if (push && fifo_full)
        ovf_q <= 1'b1;
      else if (wr && wb_adr_i == AdrStatus && wb_dat_i[3])
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            sh_q    <= fifo_rdata;
            cnt_q   <= div_q;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end else begin
            tx_q <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_zero) begin
            tx_q    <= sh_q[0];
            idx_q   <= '0;
            cnt_q   <= div_q;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StData: begin
          if (cnt_zero) begin
            cnt_q <= div_q;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStop: begin
          if (cnt_zero) begin
            if (!fifo_empty) begin
              sh_q    <= fifo_rdata;
              cnt_q   <= div_q;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_peri_uart_tx.sv
// Scoreboard bench for peri_uart_tx: bus and line expectations are queued, monitors check them.
module tb_peri_uart_tx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wb_stb_i, wb_we_i;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o, tx_o, busy_o;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  peri_uart_tx #(
    .DEPTH     (8),
    .DIV_RESET (16'd103)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .tx_o     (tx_o),
    .busy_o   (busy_o)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int    exp_dat;
    int    exp_cyc;
    string name;
  } bus_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start_cyc;
    bit         contig;
  } frame_t;

  bus_t   bq[$];
  frame_t fq[$];
  bit     line_en = 1'b1;
  int     last_end = -100;

  // Bus monitor: every ack consumes one expected access.
  bus_t be;
  always @(negedge clk_i) begin
    if (!rst_i && wb_ack_o) begin
      if (bq.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        be = bq.pop_front();
        check({be.name, "_data"}, int'(wb_dat_o), be.exp_dat);
        check({be.name, "_ack_cycle"}, cyc, be.exp_cyc);
      end
    end
  end

  // Line monitor: a start bit consumes one expected frame and checks every bit-clock.
  initial begin : line_mon
    frame_t fr;
    int     bad;
    logic   lvl;
    forever begin
      @(negedge clk_i);
      if (line_en && !rst_i && tx_o === 1'b0) begin
        if (fq.size() == 0) begin
          check("unexpected_frame", 1, 0);
          for (int i = 0; i < 400 && tx_o === 1'b0; i++) @(negedge clk_i);
        end else begin
          fr = fq.pop_front();
          if (fr.start_cyc >= 0) check($sformatf("frame_%02h_start", fr.data), cyc, fr.start_cyc);
          if (fr.contig) check($sformatf("frame_%02h_contig", fr.data), cyc, last_end + 1);
          bad = 0;
          for (int b = 0; b < 10; b++) begin
            for (int k = 0; k <= fr.div; k++) begin
              if (b != 0 || k != 0) @(negedge clk_i);
              lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : fr.data[b-1];
              if (tx_o !== lvl) bad++;
            end
          end
          last_end = cyc;
          check($sformatf("frame_%02h_bits", fr.data), bad, 0);
        end
      end
    end
  end

  // Drives one access from a negedge and returns at the negedge where ack is seen.
  task automatic bus(input bit we, input logic [3:0] adr, input logic [7:0] dat,
                     input int exp, input int lat, input string name, output int ack_cyc);
    bus_t e;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_adr_i  = adr;
    wb_dat_i  = dat;
    e.exp_dat = exp;
    e.exp_cyc = cyc + lat;
    e.name    = name;
    bq.push_back(e);
    ack_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (wb_ack_o) begin
        ack_cyc = cyc;
        break;
      end
    end
    wb_stb_i = 1'b0;
    if (ack_cyc < 0) begin
      check({name, "_ack_timeout"}, 0, 1);
      void'(bq.pop_back());
    end
  endtask

  task automatic acc(input bit we, input logic [3:0] adr, input logic [7:0] dat,
                     input int exp, input string name);
    int a;
    bus(we, adr, dat, exp, 1, name, a);
    @(negedge clk_i);
  endtask

  task automatic add_frame(input logic [7:0] d, input int div, input int sc, input bit contig);
    frame_t f;
    f.data = d; f.div = div; f.start_cyc = sc; f.contig = contig;
    fq.push_back(f);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a, a1, a2, a3;
    rst_i = 1'b1; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_tx", int'(tx_o), 1);
    check("rst_ack", int'(wb_ack_o), 0);
    check("rst_dat", int'(wb_dat_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: reset register values
    acc(0, 4'h1, 8'h00, 'h01, "t1_status");
    acc(0, 4'h2, 8'h00, 'h67, "t1_divlo");
    acc(0, 4'h3, 8'h00, 'h00, "t1_divhi");
    check("t1_tx_idle", int'(tx_o), 1);

    // 2: DIV=3, one 0x55 frame of 40 clocks
    acc(1, 4'h2, 8'h03, 0, "t2_wr_divlo");
    acc(1, 4'h3, 8'h00, 0, "t2_wr_divhi");
    bus(1, 4'h0, 8'h55, 0, 1, "t2_wr_data", a);
    add_frame(8'h55, 3, a + 1, 1'b0);
    @(negedge clk_i);
    while (cyc < a + 42) @(negedge clk_i);
    check("t2_busy_done", int'(busy_o), 0);
    acc(0, 4'h1, 8'h00, 'h01, "t2_status");

    // 3: DIV=0, two abutting frames
    acc(1, 4'h2, 8'h00, 0, "t3_wr_divlo");
    bus(1, 4'h0, 8'hA5, 0, 1, "t3_wr_a5", a1);
    add_frame(8'hA5, 0, a1 + 1, 1'b0);
    bus(1, 4'h0, 8'h3C, 0, 2, "t3_wr_3c", a2);
    add_frame(8'h3C, 0, -1, 1'b1);
    bus(0, 4'h4, 8'h00, 1, 2, "t3_level1", a3);
    @(negedge clk_i);
    repeat (15) @(negedge clk_i);
    acc(0, 4'h4, 8'h00, 0, "t3_level0");
    repeat (20) @(negedge clk_i);

    // 4: serializer parked on a huge divisor, FIFO overflow
    line_en = 1'b0;
    acc(1, 4'h2, 8'hFF, 0, "t4_wr_divlo");
    acc(1, 4'h3, 8'hFF, 0, "t4_wr_divhi");
    acc(1, 4'h0, 8'h11, 0, "t4_wr_hold");
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 8; i++) acc(1, 4'h0, 8'(i), 0, "t4_wr_fill");
    acc(0, 4'h4, 8'h00, 'h08, "t4_level_full");
    acc(0, 4'h1, 8'h00, 'h06, "t4_status_full");
    acc(1, 4'h0, 8'h99, 0, "t4_wr_ninth");
    acc(0, 4'h1, 8'h00, 'h0E, "t4_status_ovf");
    acc(0, 4'h4, 8'h00, 'h08, "t4_level_after");
    acc(1, 4'h1, 8'h08, 0, "t4_clr_ovf");
    acc(0, 4'h1, 8'h00, 'h06, "t4_status_clr");

    // 5: asynchronous reset in the middle of data bit 3
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("t5_pre_tx", int'(tx_o), 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    acc(1, 4'h2, 8'h03, 0, "t5_wr_divlo");
    bus(1, 4'h0, 8'h55, 0, 1, "t5_wr_data", a);
    @(negedge clk_i);
    while (cyc < a + 18) @(negedge clk_i);
    check("t5_tx_bit3", int'(tx_o), 0);
    #1 rst_i = 1'b1;
    #1;
    check("t5_tx_async", int'(tx_o), 1);
    check("t5_busy_async", int'(busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    line_en = 1'b1;
    acc(0, 4'h4, 8'h00, 'h00, "t5_level");
    acc(0, 4'h2, 8'h00, 'h67, "t5_divlo");
    acc(0, 4'h3, 8'h00, 'h00, "t5_divhi");
    repeat (60) @(negedge clk_i);
    check("t5_tx_quiet", int'(tx_o), 1);

    // 6: unmapped addresses
    acc(0, 4'h7, 8'h00, 'h00, "t6_rd_7");
    acc(1, 4'hF, 8'hFF, 0, "t6_wr_f");
    acc(0, 4'h2, 8'h00, 'h67, "t6_divlo");
    acc(0, 4'h3, 8'h00, 'h00, "t6_divhi");
    acc(0, 4'h1, 8'h00, 'h01, "t6_status");
    acc(0, 4'h4, 8'h00, 'h00, "t6_level");

    repeat (5) @(negedge clk_i);
    check("frames_pending", fq.size(), 0);
    check("bus_pending", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/peri_uart_tx.md
Name: peri_uart_tx

Overview:
Wishbone B4 classic responder that accepts bytes over the 4-bit-address / 8-bit-data bus and shifts them out as 8N1 asynchronous serial.
It is the bus-facing end of the serial link: the host-side Wishbone controller issues accesses, and this peripheral answers them.
Bytes pass through a small synchronous FIFO; status and baud divisor are software-visible registers.

Parameters:
DEPTH, 8, TX FIFO depth in bytes; power of two, 2..64.
DIV_RESET, 16'd103, reset value of the baud divisor (bit period = DIV+1 clocks).

Ports:
clk_i  in  1  system clock; the block uses one clock.
rst_i  in  1  reset; asynchronous and active-high.
wb_stb_i  in  1  Wishbone strobe (cycle implied).
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  4  register address.
wb_dat_i  in  8  write data.
wb_dat_o  out  8  read data, valid while wb_ack_o = 1.
wb_ack_o  out  1  single-cycle acknowledge.
tx_o  out  1  serial output, idle high.
busy_o  out  1  1 while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset: tx_o=1, wb_ack_o=0, wb_dat_o=0, busy_o=0, FIFO empty, DIV=DIV_RESET, OVF=0, serializer in StIdle.
- Reset mid-frame aborts the frame immediately (tx_o high asynchronously) and discards FIFO contents.
- Bus handshake:
  - wb_ack_o is registered: it is set at the edge where wb_stb_i=1 and wb_ack_o=0, and cleared at the next edge.
  - Each ack is exactly one access. If a master holds stb, it receives an ack every second cycle, one access per ack.
  - Write side effects commit at the same edge that sets wb_ack_o.
  - wb_dat_o is registered at that edge. It is 0 whenever ack=0 and for write acks.
- Register map:
  - 0x0 DATA, W: push wb_dat_i[7:0] into the FIFO. Reads return 0.
  - 0x1 STATUS, R: {4'b0, OVF, busy, full, empty}. W: writing 1 to bit 3 clears OVF.
  - 0x2 DIV_LO, R/W: DIV[7:0].
  - 0x3 DIV_HI, R/W: DIV[15:8].
  - 0x4 LEVEL, R: FIFO count (zero-extended to 8 bits).
  - 0x5..0xF: read 0; writes ignored, still acked.
- FIFO:
  - A push is accepted iff count<DEPTH, decided on the registered count; there is no same-cycle pop bypass.
  - A push while full is dropped and sets OVF (sticky).
  - Read/write pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
  - A simultaneous push and pop (not full) leaves count unchanged.
- Serializer FSM (state_e):
  - StIdle: if FIFO non-empty, pop into an 8-bit shift register, load baud counter with DIV, tx_o<=0, go to StStart. Otherwise tx_o=1.
  - StStart: on counter==0, tx_o<=sh[0], bit index<=0, reload counter, go to StData.
  - StData: on counter==0, shift right and index+1. After bit 7 completes, tx_o<=1 and go to StStop. Data is sent LSB first.
  - StStop: on counter==0, go to StIdle. Back-to-back frames: with the FIFO non-empty, the next start bit follows the stop bit with no extra idle cycle.
  - Baud counter decrements every clock; each bit lasts DIV+1 clocks. DIV=0 is legal (1 clock/bit).
  - A DIV write mid-frame takes effect at the next counter reload.
- Latency: a DATA write acked in cycle N with the serializer idle and the FIFO empty gives tx_o=0 from cycle N+1.
- busy_o = (state!=StIdle) | !empty.

Decomposition:
- Package peri_uart_tx_pkg: state_e {StIdle, StStart, StData, StStop}; address localparams AdrData=4'h0, AdrStatus=4'h1, AdrDivLo=4'h2, AdrDivHi=4'h3, AdrLevel=4'h4.
- Sub-module fifo_sync: parameter DEPTH, WIDTH. Ports: clk_i, rst_i, push, pop, wdata, rdata (first-word fall-through), empty, full, count.
- The serializer and register decode stay in peri_uart_tx.

Test Plan:
1. Reset, then read 0x1, 0x2, 0x3 -> ack one cycle after stb; data 0x01, 0x67, 0x00; tx_o=1.
2. Write DIV_LO=0x03, DIV_HI=0x00, then DATA=0x55 -> tx_o low from the cycle after the ack. Line shows 0,1,0,1,0,1,0,1,0,1, each level 4 clocks (40 clocks total); busy_o then drops.
3. DIV=0, write 0xA5 then 0x3C back-to-back -> two 10-clock frames contiguous, second start bit immediately after first stop bit; LEVEL reads 1 then 0.
4. Hold the serializer busy with DIV=0xFFFF and push 9 bytes into DEPTH=8 -> LEVEL=8, STATUS=0x06 then 0x0E after the 9th push (OVF set). Write STATUS=0x08 -> OVF=0, 9th byte never transmitted.
5. Assert rst_i mid data bit 3 -> tx_o=1 in the same cycle without a clock edge. After release: LEVEL=0, DIV=0x0067, no residual frame.
6. Read 0x7 and write 0xF=0xFF -> both acked, read data 0x00, no register changes.
